// File: rtl/and_chk_pkg.sv
// and_chk_pkg: shared width, FSM state type and phase-to-operand mapping for the AND checker
package and_chk_pkg;
    localparam int N = 8;
    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
    typedef logic [1:0] phase_t;
    // phase bit 0 selects a = all ones, phase bit 1 selects b = all ones; returns {a, b}
    function automatic logic [2*N-1:0] phase_operands(input phase_t p);
        return {{N{p[0]}}, {N{p[1]}}};
    endfunction
endpackage

// File: rtl/exp_delay_line.sv
// exp_delay_line: DEPTH-stage shift register of {valid, data}; DEPTH=0 is a pass-through
// Ports: clk, rst (async, active-high), v_i/d_i entry in, v_o/d_o entry out DEPTH cycles later
module exp_delay_line
    import and_chk_pkg::*;
#(
    parameter int W     = N,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         v_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);
    if (DEPTH == 0) begin : g_thru
        assign v_o = v_i;
        assign d_o = d_i;
    end else begin : g_sr
        logic [DEPTH-1:0][W:0] sr_q;
        always_ff @(posedge clk or posedge rst)
            if (rst) sr_q <= '0;
            else begin
                sr_q[0] <= {v_i, d_i};
                for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
            end
        assign {v_o, d_o} = sr_q[DEPTH-1];
    end
endmodule

// File: rtl/and_stim_checker.sv
// and_stim_checker: drives the four-phase AND operand sequence and checks the DUT result
// Ports: clk, rst (async, active-high), start pulse; a_o/b_o operands, c_i DUT result;
//        busy, done, pass status, err_count (saturating 8-bit), phase (0..3)
module and_stim_checker
    import and_chk_pkg::*;
#(
    parameter int HOLD    = 10,
    parameter int LATENCY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    input  logic [N-1:0] c_i,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_count,
    output logic [1:0]   phase
);
    // one counter serves both the per-phase hold and the drain length
    localparam int CW = $clog2((HOLD > LATENCY ? HOLD : LATENCY) + 1);
    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, dl_d;
    logic [7:0]     err_q, err_d;
    logic           go, last_hold, dl_v;
    assign go        = start && (state_q == IDLE || state_q == DONE);
    assign last_hold = cnt_q == CW'(HOLD - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (go) begin
            state_d = DRIVE;
            phase_d = '0;
            cnt_d   = '0;
        end else if (state_q == DRIVE) begin
            cnt_d   = last_hold ? '0 : cnt_q + 1'b1;
            phase_d = last_hold ? phase_q + 1'b1 : phase_q;
            if (last_hold && phase_q == 2'd3) state_d = LATENCY > 0 ? DRAIN : DONE;
        end else if (state_q == DRAIN) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(LATENCY - 1)) begin
                state_d = DONE;
                cnt_d   = '0;
            end
        end
        // operands are registered so they line up with the state they belong to
        {a_d, b_d} = state_d == DRIVE ? phase_operands(phase_d) : '0;
        err_d = go ? '0 : (dl_v && c_i != dl_d && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
    end
    exp_delay_line #(.W(N), .DEPTH(LATENCY)) u_dl (
        .clk (clk),
        .rst (rst),
        .v_i (state_q == DRIVE),
        .d_i (a_q & b_q),
        .v_o (dl_v),
        .d_o (dl_d)
    );
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy      = state_q == DRIVE || state_q == DRAIN;
    assign done      = state_q == DONE;
    assign pass      = done && err_q == '0;
    assign err_count = err_q;
    assign phase     = phase_q;
endmodule

// File: tb/tb_and_stim_checker.sv
// tb_and_stim_checker: checks several checker configurations against ideal, pipelined and faulty AND DUTs
module tb_and_stim_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] start_v = '0;
    logic [6:0][7:0] a_w, b_w, c_w, err_w;
    logic [6:0][1:0] ph_w;
    logic [6:0] busy_w, done_w, pass_w;
    logic [7:0] flip = '0;
    logic [7:0] p1 = '0, p2 = '0, r1 = '0, r2 = '0, q1 = '0, q2 = '0, q3 = '0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        p1 <= a_w[1] & b_w[1]; p2 <= p1;
        r1 <= a_w[2] & b_w[2]; r2 <= r1;
        q1 <= a_w[6] & b_w[6]; q2 <= q1; q3 <= q2;
    end
    assign c_w[0] = a_w[0] & b_w[0];
    assign c_w[1] = p2;
    assign c_w[2] = r2;
    assign c_w[3] = a_w[3] | b_w[3];
    assign c_w[4] = '0;
    assign c_w[5] = '0;
    assign c_w[6] = q3 ^ flip;
    and_stim_checker #(.HOLD(10), .LATENCY(0)) u0 (.clk(clk), .rst(rst), .start(start_v[0]), .a_o(a_w[0]), .b_o(b_w[0]), .c_i(c_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .phase(ph_w[0]));
    and_stim_checker #(.HOLD(10), .LATENCY(2)) u1 (.clk(clk), .rst(rst), .start(start_v[1]), .a_o(a_w[1]), .b_o(b_w[1]), .c_i(c_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .phase(ph_w[1]));
    and_stim_checker #(.HOLD(10), .LATENCY(0)) u2 (.clk(clk), .rst(rst), .start(start_v[2]), .a_o(a_w[2]), .b_o(b_w[2]), .c_i(c_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]), .phase(ph_w[2]));
    and_stim_checker #(.HOLD(10), .LATENCY(0)) u3 (.clk(clk), .rst(rst), .start(start_v[3]), .a_o(a_w[3]), .b_o(b_w[3]), .c_i(c_w[3]),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err_w[3]), .phase(ph_w[3]));
    and_stim_checker #(.HOLD(100), .LATENCY(0)) u4 (.clk(clk), .rst(rst), .start(start_v[4]), .a_o(a_w[4]), .b_o(b_w[4]), .c_i(c_w[4]),
        .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]), .err_count(err_w[4]), .phase(ph_w[4]));
    and_stim_checker #(.HOLD(300), .LATENCY(0)) u5 (.clk(clk), .rst(rst), .start(start_v[5]), .a_o(a_w[5]), .b_o(b_w[5]), .c_i(c_w[5]),
        .busy(busy_w[5]), .done(done_w[5]), .pass(pass_w[5]), .err_count(err_w[5]), .phase(ph_w[5]));
    and_stim_checker #(.HOLD(20), .LATENCY(3)) u6 (.clk(clk), .rst(rst), .start(start_v[6]), .a_o(a_w[6]), .b_o(b_w[6]), .c_i(c_w[6]),
        .busy(busy_w[6]), .done(done_w[6]), .pass(pass_w[6]), .err_count(err_w[6]), .phase(ph_w[6]));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input int i, input string tag);
        chk({tag, " a_o"}, 32'(a_w[i]), 0);
        chk({tag, " b_o"}, 32'(b_w[i]), 0);
        chk({tag, " busy"}, 32'(busy_w[i]), 0);
        chk({tag, " done"}, 32'(done_w[i]), 0);
        chk({tag, " pass"}, 32'(pass_w[i]), 0);
        chk({tag, " err"}, 32'(err_w[i]), 0);
        chk({tag, " phase"}, 32'(ph_w[i]), 0);
    endtask
    // one full run: checks the operand sequence cycle by cycle and returns busy length and injected-error count
    task automatic run(input int i, input int h, input int l, input bit noise, output int cyc, output int nerr);
        int n = 0;
        nerr = 0;
        @(negedge clk); start_v[i] = 1'b1;
        @(negedge clk); start_v[i] = 1'b0;
        while (busy_w[i] && n < 5000) begin
            if (n < 4 * h) begin
                chk("a_o", 32'(a_w[i]), ((n / h) % 2) ? 255 : 0);
                chk("b_o", 32'(b_w[i]), ((n / h) >= 2) ? 255 : 0);
                chk("phase", 32'(ph_w[i]), n / h);
            end else chk("a_o drain", 32'(a_w[i]), 0);
            if (noise) begin
                flip = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
                if (flip != 0 && n >= l && n < 4 * h + l) nerr++;
                start_v[i] = 1'($urandom_range(1));
            end
            @(negedge clk); n++;
        end
        flip = '0;
        start_v[i] = 1'b0;
        cyc = n;
    endtask
    initial begin
        int cyc, ne, n;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) chk_idle(i, "reset");
        rst = 1'b0;
        run(0, 10, 0, 0, cyc, ne);
        chk("ideal cycles", cyc, 40);
        chk("ideal done", 32'(done_w[0]), 1);
        chk("ideal pass", 32'(pass_w[0]), 1);
        chk("ideal err", 32'(err_w[0]), 0);
        run(1, 10, 2, 0, cyc, ne);
        chk("lat2 cycles", cyc, 42);
        chk("lat2 err", 32'(err_w[1]), 0);
        chk("lat2 pass", 32'(pass_w[1]), 1);
        run(2, 10, 0, 0, cyc, ne);
        chk("lat mismatch cycles", cyc, 40);
        chk("lat mismatch err", 32'(err_w[2]), 2);
        chk("lat mismatch pass", 32'(pass_w[2]), 0);
        run(3, 10, 0, 0, cyc, ne);
        chk("or err", 32'(err_w[3]), 20);
        chk("or pass", 32'(pass_w[3]), 0);
        chk("or done", 32'(done_w[3]), 1);
        @(negedge clk); start_v[3] = 1'b1;
        @(negedge clk); start_v[3] = 1'b0;
        chk("rearm done", 32'(done_w[3]), 0);
        chk("rearm err", 32'(err_w[3]), 0);
        chk("rearm busy", 32'(busy_w[3]), 1);
        n = 0;
        while (busy_w[3] && n < 100) begin @(negedge clk); n++; end
        chk("rearm final err", 32'(err_w[3]), 20);
        run(4, 100, 0, 0, cyc, ne);
        chk("zero100 err", 32'(err_w[4]), 100);
        chk("zero100 pass", 32'(pass_w[4]), 0);
        run(5, 300, 0, 0, cyc, ne);
        chk("zero300 cycles", cyc, 1200);
        chk("zero300 err", 32'(err_w[5]), 255);
        chk("zero300 pass", 32'(pass_w[5]), 0);
        run(6, 20, 3, 1, cyc, ne);
        chk("noise cycles", cyc, 83);
        chk("noise err", 32'(err_w[6]), ne > 255 ? 255 : ne);
        chk("noise pass", 32'(pass_w[6]), ne == 0);
        @(negedge clk); start_v[1] = 1'b1; start_v[3] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0; start_v[3] = 1'b0;
        repeat (25) @(negedge clk);
        chk("pre-reset err", 32'(err_w[3]), 15);
        chk("pre-reset phase", 32'(ph_w[3]), 2);
        #2 rst = 1'b1;
        #1;
        chk_idle(1, "async lat2");
        chk_idle(3, "async or");
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle(1, "post-reset lat2");
        chk_idle(3, "post-reset or");
        run(1, 10, 2, 0, cyc, ne);
        chk("clean cycles", cyc, 42);
        chk("clean err", 32'(err_w[1]), 0);
        chk("clean pass", 32'(pass_w[1]), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
